ssc_mem_arbiter: RTL and testbench
==================================

Name: ssc_mem_arbiter

Overview:
Two-requester arbiter for the single sort-circuit memory port.
- Requester 0 is the sort engine; requester 1 is the BIST/loader engine.
- Grants are exclusive and held until the owner releases; an owner that holds too long while the other side waits is preempted.
- Sits between both engines and the shared memory. It drives address, Write_data and the read/write strobes, and fans read data back to both engines.

Parameters:
AW, 8, address width
DW, 16, data width
HOLD_MAX, 64, max consecutive owned cycles before forced release if the other side waits; 0 disables preemption

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req0  input  1  sort engine requests the port
read0  input  1  sort engine read strobe
write0  input  1  sort engine write strobe
addr0  input  AW  sort engine address
wdata0  input  DW  sort engine write data
gnt0  output  1  sort engine owns the port
req1  input  1  BIST engine requests the port
read1  input  1  BIST engine read strobe
write1  input  1  BIST engine write strobe
addr1  input  AW  BIST engine address
wdata1  input  DW  BIST engine write data
gnt1  output  1  BIST engine owns the port
Read_data  input  DW  memory read data
rdata  output  DW  Read_data passed through, shared by both engines
address  output  AW  memory address
Write_data  output  DW  memory write data
read  output  1  memory read strobe
write  output  1  memory write strobe
preempt  output  1  one-cycle pulse when a forced release occurs
err  output  1  sticky: a strobe was asserted without grant

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - gnt0=gnt1=0, preempt=0, err=0, hold_cnt=0, last=1 (so requester 0 wins the first tie).
- States: IDLE, OWN0, OWN1. gnt0 = (state==OWN0) and gnt1 = (state==OWN1), both decoded from registered state.
- IDLE:
  - req0 only -> OWN0.
  - req1 only -> OWN1.
  - Both -> the requester not equal to last (round-robin).
  - Neither -> stay in IDLE.
  - Grant latency is 1 cycle from the edge that samples req.
- OWNn:
  - req_n=0 at an edge -> IDLE; last<=n.
  - Otherwise stay; hold_cnt increments each owned cycle and saturates at HOLD_MAX.
- Preemption:
  - Trigger: HOLD_MAX!=0 AND hold_cnt==HOLD_MAX-1 AND other req=1.
  - Next state is IDLE; last<=n; preempt pulses for 1 cycle, aligned with the first IDLE cycle.
  - The preempted owner must tolerate losing gnt while req is still high, then re-arbitrate.
- Turnaround: every ownership change passes through at least one IDLE cycle. gnt0 and gnt1 are never high together.
- hold_cnt clears to 0 in IDLE.
- Memory mux (combinational from state):
  - OWN0 -> address=addr0, Write_data=wdata0, read=read0, write=write0.
  - OWN1 -> the same from requester 1.
  - IDLE -> address=0, Write_data=0, read=0, write=0.
- rdata = Read_data at all times. Memory timing is owned by the requester.
- err: set on any cycle where (read_n|write_n) & ~gnt_n for either n. Cleared only by reset. Blocked strobes never reach the memory.
- Simultaneous release and new request by the same owner: release wins. The owner re-requests from IDLE and gets no priority over a waiting peer.
- Reset mid-access: strobes drop immediately (asynchronous), and the memory sees no further access.

Test Plan:
- Reset released, req0=1 at edge 1 -> gnt0=1 after edge 1. addr0=8'h05 and read0=1 give address=8'h05 and read=1; gnt1=0 throughout.
- req0 and req1 rise on the same edge right after reset -> gnt0 first. Then req0 drops -> 1 IDLE cycle (all strobes 0), then gnt1=1.
- Both held continuously with HOLD_MAX=4 -> ownership alternates OWN0 (4 cycles), IDLE, OWN1 (4), IDLE, and so on; preempt pulses at each IDLE.
- HOLD_MAX=0, req0 held 200 cycles with req1 waiting -> gnt0 stays 1, preempt never asserts, gnt1 waits until req0 drops.
- Owner 0 writes addr 8'h10 with data 16'hBEEF while write1=1 without grant -> write=1 and Write_data=16'hBEEF only; err=1 next cycle and stays set.
- rst asserted low mid-OWN1 with write1=1 -> write, gnt1 and err go to 0 at once without a clock. After release, req1 is re-granted with 1-cycle latency.

Source files
------------

// File: rtl/ssc_mem_arbiter.sv
// ssc_mem_arbiter: round-robin two-requester arbiter for the shared sort-circuit memory port
module ssc_mem_arbiter #(
   parameter int AW       = 8,
   parameter int DW       = 16,
   parameter int HOLD_MAX = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          read0,
   input  logic          write0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          gnt0,
   input  logic          req1,
   input  logic          read1,
   input  logic          write1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt1,
   input  logic [DW-1:0] Read_data,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] address,
   output logic [DW-1:0] Write_data,
   output logic          read,
   output logic          write,
   output logic          preempt,
   output logic          err
);
   localparam int CW = HOLD_MAX > 0 ? $clog2(HOLD_MAX + 1) : 1;
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] hold_q, hold_d;
   logic          last_q, last_d, preempt_q, preempt_d, err_q, err_d;
   logic          own_req, oth_req, expire;
   always_comb begin
      own_req   = (state_q == OWN0) ? req0 : req1;
      oth_req   = (state_q == OWN0) ? req1 : req0;
      expire    = (HOLD_MAX != 0) && (hold_q == CW'(HOLD_MAX - 1)) && oth_req;
      state_d   = state_q;
      hold_d    = hold_q;
      last_d    = last_q;
      preempt_d = 1'b0;
      if (state_q == IDLE) begin
         hold_d  = '0;
         state_d = (req0 && (!req1 || last_q)) ? OWN0 : req1 ? OWN1 : IDLE;
      end else if (!own_req || expire) begin
         // release takes priority; preempt flags only a forced release
         state_d   = IDLE;
         hold_d    = '0;
         last_d    = (state_q == OWN1);
         preempt_d = own_req;
      end else if (hold_q != CW'(HOLD_MAX)) begin
         hold_d = hold_q + 1'b1;
      end
      err_d = err_q | ((read0 | write0) & ~gnt0) | ((read1 | write1) & ~gnt1);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         hold_q    <= '0;
         last_q    <= 1'b1;
         preempt_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         last_q    <= last_d;
         preempt_q <= preempt_d;
         err_q     <= err_d;
      end
   end
   assign gnt0       = (state_q == OWN0);
   assign gnt1       = (state_q == OWN1);
   assign address    = gnt0 ? addr0 : gnt1 ? addr1 : '0;
   assign Write_data = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
   assign read       = gnt0 ? read0 : gnt1 & read1;
   assign write      = gnt0 ? write0 : gnt1 & write1;
   assign rdata      = Read_data;
   assign preempt    = preempt_q;
   assign err        = err_q;
endmodule

// File: tb/tb_ssc_mem_arbiter.sv
// tb_ssc_mem_arbiter: vector table, corner sequences and a randomized run against an ownership model
module tb_ssc_mem_arbiter;
   localparam int HM = 4;
   logic        clk = 1'b0, rst = 1'b0;
   logic        req0 = 0, read0 = 0, write0 = 0, req1 = 0, read1 = 0, write1 = 0;
   logic [7:0]  addr0 = 0, addr1 = 0;
   logic [15:0] wdata0 = 0, wdata1 = 0, Read_data = 0;
   logic        gnt0, gnt1, read, write, preempt, err;
   logic [15:0] rdata, Write_data;
   logic [7:0]  address;
   logic        n_gnt0, n_gnt1, n_read, n_write, n_preempt, n_err;
   logic [15:0] n_rdata, n_wd;
   logic [7:0]  n_address;
   int n_vec = 0, n_bad = 0;
   int m_own, m_age, m_last;
   bit m_pre, m_err;

   ssc_mem_arbiter #(.AW(8), .DW(16), .HOLD_MAX(HM)) dut (
      .clk(clk), .rst(rst), .req0(req0), .read0(read0), .write0(write0), .addr0(addr0),
      .wdata0(wdata0), .gnt0(gnt0), .req1(req1), .read1(read1), .write1(write1),
      .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .Read_data(Read_data), .rdata(rdata),
      .address(address), .Write_data(Write_data), .read(read), .write(write),
      .preempt(preempt), .err(err));

   ssc_mem_arbiter #(.AW(8), .DW(16), .HOLD_MAX(0)) dut_np (
      .clk(clk), .rst(rst), .req0(req0), .read0(read0), .write0(write0), .addr0(addr0),
      .wdata0(wdata0), .gnt0(n_gnt0), .req1(req1), .read1(read1), .write1(write1),
      .addr1(addr1), .wdata1(wdata1), .gnt1(n_gnt1), .Read_data(Read_data), .rdata(n_rdata),
      .address(n_address), .Write_data(n_wd), .read(n_read), .write(n_write),
      .preempt(n_preempt), .err(n_err));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 0;
      {req0, read0, write0, req1, read1, write1} = '0;
      @(negedge clk);
      rst = 1;
      m_own = -1; m_age = 0; m_last = 1; m_pre = 0; m_err = 0;
   endtask

   // ownership model: who holds the port, for how many cycles, and who went last
   task automatic model_edge();
      bit r0 = req0, r1 = req1;
      m_err = m_err | ((read0 | write0) && m_own != 0) | ((read1 | write1) && m_own != 1);
      m_pre = 0;
      if (m_own < 0) begin
         m_own = (r0 && r1) ? (m_last == 0 ? 1 : 0) : r0 ? 0 : r1 ? 1 : -1;
         m_age = 1;
      end else if (!(m_own == 0 ? r0 : r1)) begin
         m_last = m_own; m_own = -1;
      end else if (m_age == HM && (m_own == 0 ? r1 : r0)) begin
         m_last = m_own; m_own = -1; m_pre = 1;
      end else m_age++;
   endtask

   task automatic check_model();
      chk("rnd_gnt0", gnt0, m_own == 0);
      chk("rnd_gnt1", gnt1, m_own == 1);
      chk("rnd_preempt", preempt, m_pre);
      chk("rnd_err", err, m_err);
      chk("rnd_addr", address, m_own == 0 ? addr0 : m_own == 1 ? addr1 : 8'h0);
      chk("rnd_wdata", Write_data, m_own == 0 ? wdata0 : m_own == 1 ? wdata1 : 16'h0);
      chk("rnd_read", read, m_own == 0 ? read0 : m_own == 1 ? read1 : 1'b0);
      chk("rnd_write", write, m_own == 0 ? write0 : m_own == 1 ? write1 : 1'b0);
      chk("rnd_rdata", rdata, Read_data);
   endtask

   typedef struct {
      logic r0, r1, rd0, wr0, rd1, wr1;
      logic g0, g1, rd, wr, pre, er;
      logic [7:0] ad;
   } vec_t;
   vec_t tv[16];

   initial begin
      tv[0]  = '{1,1,0,0,0,0, 1,0,0,0,0,0, 8'h05};
      tv[1]  = '{1,1,1,0,0,0, 1,0,1,0,0,0, 8'h05};
      tv[2]  = '{1,1,0,0,0,0, 1,0,0,0,0,0, 8'h05};
      tv[3]  = '{1,1,0,0,0,0, 1,0,0,0,0,0, 8'h05};
      tv[4]  = '{1,1,0,0,0,0, 0,0,0,0,1,0, 8'h00};
      tv[5]  = '{1,1,0,0,0,0, 0,1,0,0,0,0, 8'h0A};
      tv[6]  = '{1,0,0,0,0,0, 0,0,0,0,0,0, 8'h00};
      tv[7]  = '{1,0,0,0,0,0, 1,0,0,0,0,0, 8'h05};
      tv[8]  = '{0,0,0,0,0,0, 0,0,0,0,0,0, 8'h00};
      tv[9]  = '{0,0,0,0,0,0, 0,0,0,0,0,0, 8'h00};
      tv[10] = '{0,1,0,0,0,0, 0,1,0,0,0,0, 8'h0A};
      tv[11] = '{0,1,0,0,0,1, 0,1,0,1,0,0, 8'h0A};
      tv[12] = '{1,0,0,0,0,0, 0,0,0,0,0,0, 8'h00};
      tv[13] = '{1,0,0,0,0,0, 1,0,0,0,0,0, 8'h05};
      tv[14] = '{1,0,0,0,1,0, 1,0,0,0,0,1, 8'h05};
      tv[15] = '{0,0,0,0,0,0, 0,0,0,0,0,1, 8'h00};

      #3;
      chk("rst_gnt0", gnt0, 0);
      chk("rst_gnt1", gnt1, 0);
      chk("rst_preempt", preempt, 0);
      chk("rst_err", err, 0);
      do_reset();
      addr0 = 8'h05; addr1 = 8'h0A;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         {req0, req1, read0, write0, read1, write1} =
            {tv[i].r0, tv[i].r1, tv[i].rd0, tv[i].wr0, tv[i].rd1, tv[i].wr1};
         @(posedge clk);
         #1;
         chk($sformatf("tv%0d_gnt0", i), gnt0, tv[i].g0);
         chk($sformatf("tv%0d_gnt1", i), gnt1, tv[i].g1);
         chk($sformatf("tv%0d_read", i), read, tv[i].rd);
         chk($sformatf("tv%0d_write", i), write, tv[i].wr);
         chk($sformatf("tv%0d_preempt", i), preempt, tv[i].pre);
         chk($sformatf("tv%0d_err", i), err, tv[i].er);
         chk($sformatf("tv%0d_addr", i), address, tv[i].ad);
      end

      // preemption disabled: owner keeps the port indefinitely
      do_reset();
      @(negedge clk);
      req0 = 1; req1 = 1;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         chk("np_gnt0", n_gnt0, 1);
         chk("np_gnt1", n_gnt1, 0);
         chk("np_preempt", n_preempt, 0);
      end
      @(negedge clk);
      req0 = 0;
      @(posedge clk);
      #1;
      chk("np_idle_gnt0", n_gnt0, 0);
      chk("np_idle_gnt1", n_gnt1, 0);
      @(posedge clk);
      #1;
      chk("np_gnt1_after", n_gnt1, 1);

      // write by owner 0 while requester 1 strobes without grant
      do_reset();
      @(negedge clk);
      req0 = 1;
      @(negedge clk);
      write0 = 1; addr0 = 8'h10; wdata0 = 16'hBEEF;
      write1 = 1; addr1 = 8'h22; wdata1 = 16'h1234;
      #1;
      chk("wr_write", write, 1);
      chk("wr_data", Write_data, 16'hBEEF);
      chk("wr_addr", address, 8'h10);
      chk("wr_err_before", err, 0);
      @(posedge clk);
      #1;
      chk("wr_err_set", err, 1);
      @(negedge clk);
      write0 = 0; write1 = 0; req0 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("wr_err_sticky", err, 1);

      // asynchronous reset in the middle of an OWN1 write
      do_reset();
      @(negedge clk);
      req1 = 1;
      @(posedge clk);
      #1;
      chk("ar_gnt1", gnt1, 1);
      @(negedge clk);
      write1 = 1; write0 = 1;
      @(posedge clk);
      #1;
      chk("ar_err", err, 1);
      chk("ar_write", write, 1);
      #2;
      rst = 0;
      #1;
      chk("ar_write_drop", write, 0);
      chk("ar_gnt1_drop", gnt1, 0);
      chk("ar_err_drop", err, 0);
      @(negedge clk);
      rst = 1; write1 = 0; write0 = 0;
      @(posedge clk);
      #1;
      chk("ar_regrant", gnt1, 1);

      // randomized traffic against the ownership model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (i == 300) begin
            rst = 0;
            #1;
            rst = 1;
            m_own = -1; m_age = 0; m_last = 1; m_pre = 0; m_err = 0;
         end
         if ($urandom_range(0, 5) == 0) req0 = ~req0;
         if ($urandom_range(0, 5) == 0) req1 = ~req1;
         read0  = gnt0 ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 199) == 0);
         write0 = gnt0 ? 1'($urandom_range(0, 1)) : 1'b0;
         read1  = gnt1 ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 199) == 0);
         write1 = gnt1 ? 1'($urandom_range(0, 1)) : 1'b0;
         addr0 = 8'($urandom); addr1 = 8'($urandom);
         wdata0 = 16'($urandom); wdata1 = 16'($urandom); Read_data = 16'($urandom);
         model_edge();
         @(posedge clk);
         #1;
         check_model();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
